// File: rtl/ws_tile_sequencer.sv
// ws_tile_sequencer
//   Multi-tile sequencer for a weight-stationary PE array. For each tile it
//   fills the ROWSxCOLS weight tile, streams L iact vectors into the array with
//   a one-cycle skew per column, and writes back each row's psums with a
//   one-cycle skew per row. The whole run repeats for cfg_num_tiles tiles.
//
// Ports
//   clk, rst_n                  clock / asynchronous active-low reset
//   go, abort                   start pulse (IDLE only) / synchronous abort
//   cfg_num_tiles, cfg_iact_len run configuration, latched on an accepted go
//   busy, done                  run status: busy outside IDLE, done pulse at end
//   load_weight, weight_addr    weight memory address and BRAM-aligned shift enable
//   load_iact, iact_addr        per-column iact address valid and address
//   psum_valid, psum_addr       per-row psum write enable and address
//
// Every output is a register loaded from the next-cycle value of the control
// state, so each strobe is high in the same cycle as the state it belongs to.
module ws_tile_sequencer #(
   parameter int ARRAY_ROWS = 3,
   parameter int ARRAY_COLS = 3,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int MEM_LAT    = 1,
   parameter int PSUM_LAT   = 3
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  go,
   input  logic                                  abort,
   input  logic [LEN_W-1:0]                      cfg_num_tiles,
   input  logic [LEN_W-1:0]                      cfg_iact_len,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  load_weight,
   output logic [ADDR_W-1:0]                     weight_addr,
   output logic [ARRAY_COLS-1:0]                 load_iact,
   output logic [ARRAY_COLS-1:0][ADDR_W-1:0]     iact_addr,
   output logic [ARRAY_ROWS-1:0]                 psum_valid,
   output logic [ARRAY_ROWS-1:0][ADDR_W-1:0]     psum_addr
);

   localparam int PSUM_DLY    = MEM_LAT + PSUM_LAT;
   // STREAM length is L plus the larger of the iact skew and the psum drain.
   localparam int STREAM_TAIL = (ARRAY_COLS - 1 > PSUM_DLY + ARRAY_ROWS - 1) ?
                                (ARRAY_COLS - 1) : (PSUM_DLY + ARRAY_ROWS - 1);
   localparam int LOADW_LAST  = ARRAY_COLS + MEM_LAT - 1;
   localparam int CNT_W       = LEN_W + 8;

   typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DONE} state_t;

   state_t                   state, nxt_state;
   logic [CNT_W-1:0]         cnt, nxt_cnt, stream_last;
   logic [LEN_W-1:0]         tile, nxt_tile, tile_inc;
   logic [LEN_W-1:0]         num_tiles_q, nxt_num_tiles, iact_len_q, nxt_iact_len;
   logic [ADDR_W-1:0]        wbase, nxt_wbase, ibase, nxt_ibase;
   logic                     zero_go;

   logic                                 nxt_av;
   logic [ADDR_W-1:0]                    nxt_weight_addr;
   logic [ARRAY_COLS-1:0]                nxt_load_iact;
   logic [ARRAY_COLS-1:0][ADDR_W-1:0]    nxt_iact_addr;
   logic [ARRAY_ROWS-1:0]                nxt_psum_valid;
   logic [ARRAY_ROWS-1:0][ADDR_W-1:0]    nxt_psum_addr;

   // weight address-valid and its MEM_LAT-deep delay line to the BRAM data
   logic                     av_p0;
   logic [MEM_LAT-1:0]       lw_p1;

   assign stream_last = CNT_W'(iact_len_q) + CNT_W'(STREAM_TAIL) - CNT_W'(1);
   assign tile_inc    = tile + LEN_W'(1);
   assign zero_go     = (state == S_IDLE) && go && !abort &&
                        ((cfg_num_tiles == '0) || (cfg_iact_len == '0));
   assign load_weight = lw_p1[MEM_LAT-1];

   always_comb begin : next_ctrl
      nxt_state     = state;
      nxt_cnt       = cnt;
      nxt_tile      = tile;
      nxt_wbase     = wbase;
      nxt_ibase     = ibase;
      nxt_num_tiles = num_tiles_q;
      nxt_iact_len  = iact_len_q;
      case (state)
         S_IDLE: begin
            if (go && (cfg_num_tiles != '0) && (cfg_iact_len != '0)) begin
               nxt_state     = S_LOAD_W;
               nxt_cnt       = '0;
               nxt_tile      = '0;
               nxt_wbase     = '0;
               nxt_ibase     = '0;
               nxt_num_tiles = cfg_num_tiles;
               nxt_iact_len  = cfg_iact_len;
            end
         end
         S_LOAD_W: begin
            if (cnt == CNT_W'(LOADW_LAST)) begin
               nxt_state = S_STREAM;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         S_STREAM: begin
            if (cnt == stream_last) begin
               nxt_cnt   = '0;
               nxt_tile  = tile_inc;
               nxt_wbase = wbase + ADDR_W'(ARRAY_COLS);
               nxt_ibase = ibase + ADDR_W'(iact_len_q);
               nxt_state = (tile_inc == num_tiles_q) ? S_DONE : S_LOAD_W;
            end else begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
      if (abort) begin
         nxt_state = S_IDLE;
         nxt_cnt   = '0;
      end
   end

   // Output values for the next cycle, decoded from the next control state.
   always_comb begin : next_out
      nxt_av          = (nxt_state == S_LOAD_W) && (nxt_cnt < CNT_W'(ARRAY_COLS));
      nxt_weight_addr = weight_addr;
      if (abort)
         nxt_weight_addr = '0;
      else if (nxt_av)
         nxt_weight_addr = nxt_wbase + ADDR_W'(nxt_cnt);
      nxt_load_iact  = '0;
      nxt_iact_addr  = '0;
      nxt_psum_valid = '0;
      nxt_psum_addr  = '0;
      for (int c = 0; c < ARRAY_COLS; c++) begin
         if ((nxt_state == S_STREAM) && (nxt_cnt >= CNT_W'(c)) &&
             ((nxt_cnt - CNT_W'(c)) < CNT_W'(nxt_iact_len))) begin
            nxt_load_iact[c] = 1'b1;
            nxt_iact_addr[c] = nxt_ibase + ADDR_W'(nxt_cnt - CNT_W'(c));
         end
      end
      for (int r = 0; r < ARRAY_ROWS; r++) begin
         if ((nxt_state == S_STREAM) && (nxt_cnt >= CNT_W'(PSUM_DLY + r)) &&
             ((nxt_cnt - CNT_W'(PSUM_DLY + r)) < CNT_W'(nxt_iact_len))) begin
            nxt_psum_valid[r] = 1'b1;
            nxt_psum_addr[r]  = nxt_ibase + ADDR_W'(nxt_cnt - CNT_W'(PSUM_DLY + r));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         tile        <= '0;
         wbase       <= '0;
         ibase       <= '0;
         num_tiles_q <= '0;
         iact_len_q  <= '0;
         av_p0       <= 1'b0;
         lw_p1       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         weight_addr <= '0;
         load_iact   <= '0;
         iact_addr   <= '0;
         psum_valid  <= '0;
         psum_addr   <= '0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         tile        <= nxt_tile;
         wbase       <= nxt_wbase;
         ibase       <= nxt_ibase;
         num_tiles_q <= nxt_num_tiles;
         iact_len_q  <= nxt_iact_len;
         // address phase -> BRAM data phase; abort flushes words in flight
         av_p0       <= nxt_av;
         lw_p1[0]    <= av_p0 && !abort;
         for (int i = 1; i < MEM_LAT; i++)
            lw_p1[i] <= lw_p1[i-1] && !abort;
         busy        <= (nxt_state != S_IDLE);
         done        <= (nxt_state == S_DONE) || zero_go;
         weight_addr <= nxt_weight_addr;
         load_iact   <= nxt_load_iact;
         iact_addr   <= nxt_iact_addr;
         psum_valid  <= nxt_psum_valid;
         psum_addr   <= nxt_psum_addr;
      end
   end

endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Testbench for ws_tile_sequencer: directed scenarios plus randomized runs.
// A reference model turns every accepted go into the list of expected strobe
// events (cycle, address) per channel; a monitor pops and compares them as
// the DUT raises each strobe.
module tb_ws_tile_sequencer;

   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int ML   = 1;
   localparam int PL   = 3;
   localparam int MAXC = 8000;

   typedef struct {
      int          cyc;
      longint      addr;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic go = 1'b0, abort = 1'b0;
   logic [15:0] cfg_num_tiles = '0, cfg_iact_len = '0;
   logic busy, done, load_weight;
   logic [31:0] weight_addr;
   logic [COLS-1:0] load_iact;
   logic [COLS-1:0][31:0] iact_addr;
   logic [ROWS-1:0] psum_valid;
   logic [ROWS-1:0][31:0] psum_addr;

   // narrow-address instance for the wraparound scenario
   logic go4 = 1'b0, abort4 = 1'b0;
   logic [15:0] nt4 = '0, len4 = '0;
   logic busy4, done4, lw4;
   logic [3:0] wa4;
   logic [COLS-1:0] li4;
   logic [COLS-1:0][3:0] ia4;
   logic [ROWS-1:0] pv4;
   logic [ROWS-1:0][3:0] pa4;

   ws_tile_sequencer #(.ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .ADDR_W(32), .LEN_W(16),
                       .MEM_LAT(ML), .PSUM_LAT(PL)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
      .cfg_num_tiles(cfg_num_tiles), .cfg_iact_len(cfg_iact_len),
      .busy(busy), .done(done), .load_weight(load_weight), .weight_addr(weight_addr),
      .load_iact(load_iact), .iact_addr(iact_addr),
      .psum_valid(psum_valid), .psum_addr(psum_addr));

   ws_tile_sequencer #(.ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .ADDR_W(4), .LEN_W(16),
                       .MEM_LAT(ML), .PSUM_LAT(PL)) dut4 (
      .clk(clk), .rst_n(rst_n), .go(go4), .abort(abort4),
      .cfg_num_tiles(nt4), .cfg_iact_len(len4),
      .busy(busy4), .done(done4), .load_weight(lw4), .weight_addr(wa4),
      .load_iact(li4), .iact_addr(ia4),
      .psum_valid(pv4), .psum_addr(pa4));

   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   ev_t wq[$];
   ev_t iq[COLS][$];
   ev_t pq[ROWS][$];
   int  dq[$];
   longint q4[$];
   bit  exp_busy [0:MAXC-1];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   // Expected behaviour of one go, from the sequencing rules.
   task automatic model_run(input int g0, input int nt, input int len, output int tend);
      int t, s, wb, ib;
      if (nt == 0 || len == 0) begin
         dq.push_back(g0 + 1);
         tend = g0 + 1;
         return;
      end
      t = g0 + 1;
      for (int i = 0; i < nt; i++) begin
         wb = i * COLS;
         ib = i * len;
         for (int k = 0; k < COLS; k++) wq.push_back('{t + ML + k, wb + k});
         s = t + COLS + ML;
         for (int c = 0; c < COLS; c++)
            for (int j = 0; j < len; j++) iq[c].push_back('{s + c + j, ib + j});
         for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < len; j++) pq[r].push_back('{s + ML + PL + r + j, ib + j});
         if (COLS - 1 + len > ML + PL + ROWS - 1 + len) t = s + COLS - 1 + len;
         else t = s + ML + PL + ROWS - 1 + len;
      end
      dq.push_back(t);
      for (int x = g0 + 1; x <= t; x++) exp_busy[x] = 1'b1;
      tend = t;
   endtask

   // Abort/reset: nothing expected from cycle 'cut' on.
   task automatic truncate(input int cut);
      while (wq.size() > 0 && wq[$].cyc >= cut) void'(wq.pop_back());
      for (int c = 0; c < COLS; c++)
         while (iq[c].size() > 0 && iq[c][$].cyc >= cut) void'(iq[c].pop_back());
      for (int r = 0; r < ROWS; r++)
         while (pq[r].size() > 0 && pq[r][$].cyc >= cut) void'(pq[r].pop_back());
      while (dq.size() > 0 && dq[$] >= cut) void'(dq.pop_back());
      for (int x = cut; x < MAXC; x++) exp_busy[x] = 1'b0;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic run(input int nt, input int len, output int tend);
      cfg_num_tiles = 16'(nt);
      cfg_iact_len  = 16'(len);
      go = 1'b1;
      model_run(cyc, nt, len, tend);
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: sample outputs on the falling edge.
   initial begin
      ev_t e;
      longint wa_prev;
      wa_prev = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("busy", longint'(busy), longint'(exp_busy[cyc]));
            if (done) begin
               if (dq.size() == 0) chk("done_extra", 1, 0);
               else chk("done_cyc", cyc, dq.pop_front());
            end
            // MEM_LAT=1: the address for this data was presented last cycle
            if (load_weight) begin
               if (wq.size() == 0) chk("load_weight_extra", 1, 0);
               else begin
                  e = wq.pop_front();
                  chk("load_weight_cyc", cyc, e.cyc);
                  chk("weight_addr", wa_prev, e.addr);
               end
            end
            for (int c = 0; c < COLS; c++) begin
               if (load_iact[c]) begin
                  if (iq[c].size() == 0) chk("load_iact_extra", c, -1);
                  else begin
                     e = iq[c].pop_front();
                     chk("load_iact_cyc", cyc, e.cyc);
                     chk("iact_addr", longint'(iact_addr[c]), e.addr);
                  end
               end else begin
                  chk("iact_addr_idle", longint'(iact_addr[c]), 0);
               end
            end
            for (int r = 0; r < ROWS; r++) begin
               if (psum_valid[r]) begin
                  if (pq[r].size() == 0) chk("psum_valid_extra", r, -1);
                  else begin
                     e = pq[r].pop_front();
                     chk("psum_valid_cyc", cyc, e.cyc);
                     chk("psum_addr", longint'(psum_addr[r]), e.addr);
                  end
               end
            end
            if (pv4[0]) begin
               if (q4.size() == 0) chk("psum4_extra", 1, 0);
               else chk("psum_addr_wrap", longint'(pa4[0]), q4.pop_front());
            end
         end
         wa_prev = longint'(weight_addr);
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int tend, g0, a, nt, len;
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_load_weight", load_weight, 0);
      chk("rst_weight_addr", weight_addr, 0);
      chk("rst_load_iact", load_iact, 0);
      chk("rst_psum_valid", psum_valid, 0);
      chk("rst_psum_addr", psum_addr[ROWS-1], 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // single tile, then two tiles
      run(1, 4, tend);  wait_cyc(tend + 1);
      run(2, 4, tend);  wait_cyc(tend + 1);
      // zero configurations: done only
      run(1, 0, tend);  wait_cyc(tend + 2);
      run(0, 5, tend);  wait_cyc(tend + 2);

      // abort in the middle of a run, then restart from address 0
      g0 = cyc;
      run(1, 4, tend);
      wait_cyc(g0 + 7);
      abort = 1'b1;
      truncate(g0 + 8);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_weight_addr", weight_addr, 0);
      chk("abort_load_iact", load_iact, 0);
      wait_cyc(g0 + 10);
      run(1, 4, tend);  wait_cyc(tend + 1);

      // abort together with go in IDLE: nothing starts
      cfg_num_tiles = 16'd1;
      cfg_iact_len  = 16'd4;
      go = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      go = 1'b0;
      abort = 1'b0;
      repeat (4) @(negedge clk);

      // go and cfg changes while busy are ignored
      g0 = cyc;
      run(1, 4, tend);
      wait_cyc(g0 + 6);
      go = 1'b1;
      cfg_iact_len = 16'd9;
      @(negedge clk);
      go = 1'b0;
      wait_cyc(tend + 1);

      // asynchronous reset mid-run
      g0 = cyc;
      run(1, 4, tend);
      wait_cyc(g0 + 9);
      #2;
      rst_n = 1'b0;
      truncate(cyc + 1);
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_psum_valid", psum_valid, 0);
      chk("async_rst_load_iact", load_iact, 0);
      chk("async_rst_weight_addr", weight_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(1, 4, tend);  wait_cyc(tend + 1);

      // randomized runs with occasional aborts
      for (int it = 0; it < 24; it++) begin
         nt  = $urandom_range(0, 3);
         len = $urandom_range(0, 6);
         g0  = cyc;
         run(nt, len, tend);
         if (nt != 0 && len != 0 && $urandom_range(0, 3) == 0) begin
            a = g0 + $urandom_range(1, tend - g0);
            wait_cyc(a);
            abort = 1'b1;
            truncate(a + 1);
            @(negedge clk);
            abort = 1'b0;
         end else begin
            wait_cyc(tend + 1);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // 4-bit addresses: third tile starts at 12 and wraps
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 6; j++) q4.push_back(longint'((i * 6 + j) % 16));
      nt4  = 16'd3;
      len4 = 16'd6;
      go4  = 1'b1;
      @(negedge clk);
      go4 = 1'b0;
      repeat (60) @(negedge clk);

      repeat (5) @(negedge clk);
      chk("left_weight", wq.size(), 0);
      for (int c = 0; c < COLS; c++) chk("left_iact", iq[c].size(), 0);
      for (int r = 0; r < ROWS; r++) chk("left_psum", pq[r].size(), 0);
      chk("left_done", dq.size(), 0);
      chk("left_psum4", q4.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
